// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: sequencer states and the
// microsecond-to-clock-cycle conversion used to size delays and timeouts.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INHIBIT = 4'd1,
        REQ     = 4'd2,
        DATA    = 4'd3,
        PARITY  = 4'd4,
        STOP    = 4'd5,
        ACK     = 4'd6,
        RELEASE = 4'd7,
        FINISH  = 4'd8
    } ps2_state_e;

    localparam int unsigned US_PER_S = 32'd1_000_000;

    // 64-bit product so large clock rates times long timeouts cannot overflow.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        longint unsigned prod;
        prod = 64'(clk_hz) * 64'(us);
        return 32'(prod / 64'(US_PER_S));
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 line: two-flop synchronizer, a level filter that
// only changes after four identical samples, and a falling-edge pulse.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic [3:0] hist_q;
    logic       level_q;
    logic       fall_q;

    // Idle bus is high, so everything resets to the released level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            hist_q  <= 4'b1111;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            hist_q <= {hist_q[2:0], sync_q[1]};
            fall_q <= 1'b0;
            if (hist_q == 4'b1111) begin
                level_q <= 1'b1;
            end else if (hist_q == 4'b0000) begin
                level_q <= 1'b0;
                fall_q  <= level_q;
            end else begin
                level_q <= level_q;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, sends start,
// eight data bits LSB first, odd parity and stop, then checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int INHIBIT_US   = 120,
    parameter int START_TMO_US = 15_000,
    parameter int XFER_TMO_US  = 2_000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       send,
    input  logic [7:0] data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = us_to_cycles(CLK_HZ, START_TMO_US);
    localparam int unsigned XFER_CYC    = us_to_cycles(CLK_HZ, XFER_TMO_US);
    localparam int unsigned MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int unsigned CNT_MAX     = (MAX_A > XFER_CYC) ? MAX_A : XFER_CYC;
    localparam int          CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] INH_PRE    = CNT_W'(INHIBIT_CYC - 2);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL   = {CNT_W{1'b1}};

    ps2_state_e       state_q;
    logic [7:0]       data_q;
    logic             parity_q;
    logic [2:0]       bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ack_err_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic             clk_lvl_s;
    logic             clk_fall_s;
    logic             dat_lvl_s;
    logic             dat_fall_unused_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [2:0]       next_bit_s;
    logic             tmo_s;

    ps2_line_sync u_clk_sync (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .line_i  (ps2_clk_in),
        .level_o (clk_lvl_s),
        .fall_o  (clk_fall_s)
    );

    ps2_line_sync u_dat_sync (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .line_i  (ps2_dat_in),
        .level_o (dat_lvl_s),
        .fall_o  (dat_fall_unused_s)
    );

    // Saturating count; the start timeout uses the longer limit only while waiting in REQ.
    assign cnt_inc_s  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
    assign next_bit_s = bit_q + 3'd1;
    assign tmo_s      = (state_q == REQ) ? (cnt_q >= START_LAST) : (cnt_q >= XFER_LAST);

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            parity_q  <= 1'b0;
            bit_q     <= 3'd0;
            cnt_q     <= CNT_ZERO;
            ack_err_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (send) begin
                        data_q   <= data;
                        parity_q <= ~^data;
                        cnt_q    <= CNT_ZERO;
                        busy_q   <= 1'b1;
                        clk_oe_q <= 1'b1;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q >= INH_LAST) begin
                        clk_oe_q <= 1'b0;
                        cnt_q    <= CNT_ZERO;
                        state_q  <= REQ;
                    end else begin
                        cnt_q <= cnt_inc_s;
                        if (cnt_q == INH_PRE) begin
                            dat_oe_q <= 1'b1;
                        end
                    end
                end
                REQ, DATA, PARITY, STOP, ACK: begin
                    cnt_q <= cnt_inc_s;
                    if (tmo_s) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        done_q   <= 1'b1;
                        error_q  <= 1'b1;
                        state_q  <= FINISH;
                    end else if (clk_fall_s) begin
                        // Host changes data while the device holds the clock low.
                        case (state_q)
                            REQ: begin
                                dat_oe_q <= ~data_q[0];
                                bit_q    <= 3'd0;
                                state_q  <= DATA;
                            end
                            DATA: begin
                                dat_oe_q <= ~data_q[next_bit_s];
                                bit_q    <= next_bit_s;
                                if (next_bit_s == 3'd7) begin
                                    state_q <= PARITY;
                                end
                            end
                            PARITY: begin
                                dat_oe_q <= ~parity_q;
                                state_q  <= STOP;
                            end
                            STOP: begin
                                dat_oe_q <= 1'b0;
                                state_q  <= ACK;
                            end
                            ACK: begin
                                ack_err_q <= dat_lvl_s;
                                state_q   <= RELEASE;
                            end
                            default: begin
                                state_q <= IDLE;
                            end
                        endcase
                    end
                end
                RELEASE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    if (clk_lvl_s && dat_lvl_s) begin
                        done_q  <= 1'b1;
                        error_q <= ack_err_q;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, and captured frames are compared with frames built from the byte.
module tb_ps2_host_tx;

    localparam int CLK_HZ    = 1_000_000;
    localparam int INH_CYC   = 120;
    localparam int START_CYC = 15_000;
    localparam int HALF      = 40;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       send;
    logic [7:0] data;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic       dev_clk_pull = 1'b0;
    logic       dev_dat_pull = 1'b0;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    logic last_err = 1'b0;
    logic last_busy = 1'b0;
    logic last_clk_oe = 1'b0;
    logic last_dat_oe = 1'b0;

    ps2_host_tx #(
        .CLK_HZ       (CLK_HZ),
        .INHIBIT_US   (120),
        .START_TMO_US (15_000),
        .XFER_TMO_US  (2_000)
    ) dut (
        .Clk        (clk),
        .Reset_n    (Reset_n),
        .send       (send),
        .data       (data),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Open-drain bus: either side pulling makes the line low.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_pull);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_pull);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt    = done_cnt + 1;
            last_err    = error;
            last_busy   = busy;
            last_clk_oe = ps2_clk_oe;
            last_dat_oe = ps2_dat_oe;
        end
    end

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic pulse_send(input logic [7:0] b);
        data = b;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        data = 8'($urandom);
    endtask

    // Device: measures the inhibit, then generates n_clk clocks, reading data while clock is high.
    task automatic device_xfer(input int n_clk, input bit ack, output logic [10:0] bits,
                               output int inh_len, output int dat_at, output bit ok);
        int n;
        n = 0; bits = 11'd0; inh_len = 0; dat_at = 0; ok = 1'b1;
        while (ps2_clk_oe !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk_oe !== 1'b1) begin
            ok = 1'b0;
        end else begin
            while (ps2_clk_oe === 1'b1 && inh_len < 2 * INH_CYC) begin
                inh_len++;
                if (ps2_dat_oe === 1'b1 && dat_at == 0) dat_at = inh_len;
                @(negedge clk);
            end
            repeat ($urandom_range(60, 20)) @(negedge clk);
            bits[0] = ps2_dat_in;
            for (int i = 1; i <= n_clk; i++) begin
                dev_clk_pull = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_pull = 1'b0;
                repeat (HALF / 2) @(negedge clk);
                if (i <= 10) bits[i] = ps2_dat_in;
                if (i == 10 && ack) dev_dat_pull = 1'b1;
                repeat (HALF / 2) @(negedge clk);
            end
            dev_dat_pull = 1'b0;
        end
    endtask

    task automatic wait_done(input int c0, input int budget, output bit seen);
        int t;
        t = 0;
        while (done_cnt == c0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        seen = (done_cnt != c0);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, output logic [10:0] bits,
                             output bit seen, output int inh, output int dat_at,
                             output bit ok, output logic busy_after);
        int c0;
        c0 = done_cnt;
        fork
            device_xfer(11, ack, bits, inh, dat_at, ok);
            begin
                pulse_send(b);
                busy_after = busy;
            end
        join
        wait_done(c0, 300, seen);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; send = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        n_cmp++; if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({done, error} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, error}); end
        Reset_n = 1'b1;
    endtask

    // Sends 0xED on the very first cycle after reset release.
    task automatic test_first_send_ed();
        logic [10:0] bits; bit seen, ok; int inh, dat_at, c0; logic b1;
        c0 = done_cnt;
        run_frame(8'hED, 1'b1, bits, seen, inh, dat_at, ok, b1);
        n_cmp++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL ed_busy_next_cycle: got %b want 1", b1); end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ed_inhibit_seen: got %b want 1", ok); end
        n_cmp++; if (inh != INH_CYC) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH_CYC); end
        n_cmp++; if (dat_at != INH_CYC) begin n_fail++; $display("FAIL ed_start_cycle: got %0d want %0d", dat_at, INH_CYC); end
        n_cmp++; if (bits !== 11'b111_1101_1010) begin n_fail++; $display("FAIL ed_frame: got %b want 11111011010", bits); end
        n_cmp++; if (!seen || last_err !== 1'b0) begin n_fail++; $display("FAIL ed_done: seen %b err %b want 1 0", seen, last_err); end
        n_cmp++; if (last_busy !== 1'b1) begin n_fail++; $display("FAIL ed_busy_at_done: got %b want 1", last_busy); end
        n_cmp++; if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin n_fail++; $display("FAIL ed_idle_after: got %b want 000", {busy, ps2_clk_oe, ps2_dat_oe}); end
        n_cmp++; if (done_cnt - c0 != 1) begin n_fail++; $display("FAIL ed_done_pulses: got %0d want 1", done_cnt - c0); end
    endtask

    task automatic test_parity();
        logic [7:0] vals [6];
        logic [10:0] bits; bit seen, ok; int inh, dat_at; logic b1;
        vals[0] = 8'hF4; vals[1] = 8'hFF;
        for (int k = 2; k < 6; k++) vals[k] = 8'($urandom);
        for (int k = 0; k < 6; k++) begin
            run_frame(vals[k], 1'b1, bits, seen, inh, dat_at, ok, b1);
            n_cmp++; if (bits !== frame_model(vals[k])) begin n_fail++; $display("FAIL frame_%02h: got %b want %b", vals[k], bits, frame_model(vals[k])); end
            n_cmp++; if (!seen || last_err !== 1'b0) begin n_fail++; $display("FAIL done_%02h: seen %b err %b want 1 0", vals[k], seen, last_err); end
            if (k == 0) begin
                n_cmp++; if (bits[9] !== 1'b0) begin n_fail++; $display("FAIL parity_f4: got %b want 0", bits[9]); end
            end else if (k == 1) begin
                n_cmp++; if (bits[9] !== 1'b1) begin n_fail++; $display("FAIL parity_ff: got %b want 1", bits[9]); end
            end
        end
    endtask

    task automatic test_start_timeout();
        int n, t, c0; bit seen;
        c0 = done_cnt; n = 0; t = 0;
        pulse_send(8'($urandom));
        while (ps2_clk_oe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        while (ps2_clk_oe === 1'b1 && n < 400) begin @(negedge clk); n++; end
        n_cmp++; if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL req_start_bit: got %b want 1", ps2_dat_oe); end
        while (done_cnt == c0 && t < START_CYC + 500) begin @(negedge clk); t++; end
        seen = (done_cnt != c0);
        n_cmp++; if (!seen || t < START_CYC - 3 || t > START_CYC + 3) begin n_fail++; $display("FAIL start_tmo_time: got %0d cycles (seen %b) want %0d", t, seen, START_CYC); end
        n_cmp++; if ({last_err, last_clk_oe, last_dat_oe} !== 3'b100) begin n_fail++; $display("FAIL start_tmo_err: got %b want 100", {last_err, last_clk_oe, last_dat_oe}); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nack();
        logic [10:0] bits; bit seen, ok; int inh, dat_at; logic b1; logic [7:0] b;
        b = 8'($urandom);
        run_frame(b, 1'b0, bits, seen, inh, dat_at, ok, b1);
        n_cmp++; if (bits !== frame_model(b)) begin n_fail++; $display("FAIL nack_frame: got %b want %b", bits, frame_model(b)); end
        n_cmp++; if (!seen || last_err !== 1'b1) begin n_fail++; $display("FAIL nack_err: seen %b err %b want 1 1", seen, last_err); end
        n_cmp++; if ({last_clk_oe, last_dat_oe, ps2_clk_oe, ps2_dat_oe} !== 4'b0000) begin n_fail++; $display("FAIL nack_release: got %b want 0000", {last_clk_oe, last_dat_oe, ps2_clk_oe, ps2_dat_oe}); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits; bit seen, ok, relaunch; int inh, dat_at, c0; logic [7:0] d0, d1;
        d0 = 8'($urandom); d1 = d0 ^ 8'hA5; c0 = done_cnt; relaunch = 1'b0;
        fork
            device_xfer(11, 1'b1, bits, inh, dat_at, ok);
            begin
                pulse_send(d0);
                repeat (50) @(negedge clk);
                pulse_send(d1);
                repeat (400) @(negedge clk);
                pulse_send(d1);
            end
        join
        wait_done(c0, 300, seen);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ps2_clk_oe === 1'b1) relaunch = 1'b1;
        end
        n_cmp++; if (bits !== frame_model(d0)) begin n_fail++; $display("FAIL b2b_frame: got %b want %b", bits, frame_model(d0)); end
        n_cmp++; if (done_cnt - c0 != 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt - c0); end
        n_cmp++; if (relaunch !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_relaunch: relaunch %b busy %b want 0 0", relaunch, busy); end
    endtask

    task automatic test_reset_mid_data();
        logic [10:0] bits; bit seen, ok; int inh, dat_at, c0; logic b1; logic [7:0] b;
        c0 = done_cnt;
        fork
            device_xfer(3, 1'b1, bits, inh, dat_at, ok);
            pulse_send(8'h00);
        join
        n_cmp++; if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL mid_data_dat_oe: got %b want 1", ps2_dat_oe); end
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++; if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin n_fail++; $display("FAIL async_reset_outputs: got %b want 000", {ps2_clk_oe, ps2_dat_oe, busy}); end
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (done_cnt != c0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - c0); end
        b = 8'($urandom);
        run_frame(b, 1'b1, bits, seen, inh, dat_at, ok, b1);
        n_cmp++; if (bits !== frame_model(b)) begin n_fail++; $display("FAIL post_reset_frame: got %b want %b", bits, frame_model(b)); end
        n_cmp++; if (!seen || last_err !== 1'b0) begin n_fail++; $display("FAIL post_reset_done: seen %b err %b want 1 0", seen, last_err); end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_send_ed();
        test_parity();
        test_start_timeout();
        test_nack();
        test_back_to_back();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
